// File: rtl/idex_if.sv
// ID->EX bus bundle: decoded ID fields in, registered EX fields out.
// Pure wiring, no latency of its own.
// No backpressure on the bus itself; the stage returns hold to stall upstream.
interface idex_if #(
  parameter int DW = 32
);
  logic          id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]    id_branch, id_aluop;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_seimm;
  logic [4:0]    id_rs, id_rt, id_rd;

  logic          ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]    ex_branch, ex_aluop;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_seimm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic          ex_valid;
  logic          hold;
  logic [15:0]   bubble_count;

  // Driver side (decode stage / testbench)
  modport master (
    output id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
           id_branch, id_aluop, id_pc4, id_rd1, id_rd2, id_seimm, id_rs, id_rt, id_rd,
    input  ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
           ex_branch, ex_aluop, ex_pc4, ex_rd1, ex_rd2, ex_seimm, ex_rs, ex_rt, ex_rd,
           ex_valid, hold, bubble_count
  );

  // Pipeline register side
  modport slave (
    input  id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
           id_branch, id_aluop, id_pc4, id_rd1, id_rd2, id_seimm, id_rs, id_rt, id_rd,
    output ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
           ex_branch, ex_aluop, ex_pc4, ex_rd1, ex_rd2, ex_seimm, ex_rs, ex_rt, ex_rd,
           ex_valid, hold, bubble_count
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush squash.
// Latency: one edge from id_* to ex_*; hold is combinational in the same cycle.
// Backpressure: hold freezes PC and IF/ID for one cycle per load-use bubble.
module idex_stage #(
  parameter int DW = 32
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  idex_if.slave bus
);

  typedef struct packed {
    logic          regdst;
    logic          memread;
    logic          memtoreg;
    logic          memwrite;
    logic          alusrc;
    logic          regwrite;
    logic [1:0]    branch;
    logic [1:0]    aluop;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] seimm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          valid;
  } ex_t;

  ex_t         ex_q, ex_d, id_pkt;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        hazard;

  // Pack the decoded ID fields into one record; a captured instruction is always valid
  always_comb begin
    id_pkt          = '0;
    id_pkt.regdst   = bus.id_regdst;
    id_pkt.memread  = bus.id_memread;
    id_pkt.memtoreg = bus.id_memtoreg;
    id_pkt.memwrite = bus.id_memwrite;
    id_pkt.alusrc   = bus.id_alusrc;
    id_pkt.regwrite = bus.id_regwrite;
    id_pkt.branch   = bus.id_branch;
    id_pkt.aluop    = bus.id_aluop;
    id_pkt.pc4      = bus.id_pc4;
    id_pkt.rd1      = bus.id_rd1;
    id_pkt.rd2      = bus.id_rd2;
    id_pkt.seimm    = bus.id_seimm;
    id_pkt.rs       = bus.id_rs;
    id_pkt.rt       = bus.id_rt;
    id_pkt.rd       = bus.id_rd;
    id_pkt.valid    = 1'b1;
  end

  // Load-use detection: a load in EX whose destination ($0 excluded) feeds the ID instruction
  always_comb begin
    hazard = ex_q.memread && (ex_q.rt != 5'd0) &&
             ((ex_q.rt == bus.id_rs) || (ex_q.rt == bus.id_rt));
  end

  // Next-state select: flush beats hazard beats load; only hazard bubbles are counted
  always_comb begin
    ex_d           = id_pkt;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      ex_d = '0;
    end else if (hazard) begin
      ex_d = '0;
      if (bubble_count_q != 16'hFFFF) begin
        bubble_count_d = bubble_count_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.hold         = hazard & ~flush;
  assign bus.bubble_count = bubble_count_q;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_branch    = ex_q.branch;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.ex_pc4       = ex_q.pc4;
  assign bus.ex_rd1       = ex_q.rd1;
  assign bus.ex_rd2       = ex_q.rd2;
  assign bus.ex_seimm     = ex_q.seimm;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_valid     = ex_q.valid;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the ID/EX stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_idex_stage;

  typedef struct packed {
    logic        regdst, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  branch, aluop;
    logic [31:0] pc4, rd1, rd2, seimm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  idex_if #(.DW(32)) bus ();

  idex_stage #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: what EX holds, and how many load-use bubbles were inserted
  ins_t m_ex = '0;
  int   m_cnt = 0;
  ins_t cur  = '0;

  function automatic logic m_hazard();
    return m_ex.memread && (m_ex.rt != 5'd0) && (m_ex.rt == cur.rs || m_ex.rt == cur.rt);
  endfunction

  function automatic logic m_hold();
    return m_hazard() && !flush;
  endfunction

  function automatic ins_t dut_ex();
    ins_t o;
    o = '{bus.ex_regdst, bus.ex_memread, bus.ex_memtoreg, bus.ex_memwrite, bus.ex_alusrc,
          bus.ex_regwrite, bus.ex_branch, bus.ex_aluop, bus.ex_pc4, bus.ex_rd1, bus.ex_rd2,
          bus.ex_seimm, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_valid};
    return o;
  endfunction

  function automatic ins_t rnd_ins(input int maxreg);
    ins_t i;
    i.regdst = 1'($urandom); i.memread = 1'($urandom); i.memtoreg = 1'($urandom);
    i.memwrite = 1'($urandom); i.alusrc = 1'($urandom); i.regwrite = 1'($urandom);
    i.branch = 2'($urandom); i.aluop = 2'($urandom);
    i.pc4 = $urandom; i.rd1 = $urandom; i.rd2 = $urandom; i.seimm = $urandom;
    i.rs = 5'($urandom_range(0, maxreg)); i.rt = 5'($urandom_range(0, maxreg));
    i.rd = 5'($urandom);
    i.valid = 1'b0;
    return i;
  endfunction

  // Present an instruction with flush/reset (called at the falling edge), let hold settle
  task automatic apply(input ins_t i, input logic fl, input logic rs);
    cur = i;
    bus.id_regdst = i.regdst; bus.id_memread = i.memread; bus.id_memtoreg = i.memtoreg;
    bus.id_memwrite = i.memwrite; bus.id_alusrc = i.alusrc; bus.id_regwrite = i.regwrite;
    bus.id_branch = i.branch; bus.id_aluop = i.aluop;
    bus.id_pc4 = i.pc4; bus.id_rd1 = i.rd1; bus.id_rd2 = i.rd2; bus.id_seimm = i.seimm;
    bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
    flush = fl;
    reset = rs;
    #1;
  endtask

  // One rising edge on DUT and model, returning at the next falling edge
  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = m_hazard();
    if (reset) begin
      m_ex = '0; m_cnt = 0;
    end else if (flush) begin
      m_ex = '0;
    end else if (hz) begin
      m_ex = '0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_ex = cur; m_ex.valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    ins_t i;
    i = '1;
    @(negedge clk);
    apply(i, 1'b1, 1'b1);
    tick();
    apply(i, 1'b1, 1'b1);
    tick();
    tests++;
    if (dut_ex() !== ins_t'(0)) begin
      fails++; $display("FAIL reset_ex: got %h want 0", dut_ex());
    end
    tests++;
    if (bus.bubble_count !== 16'd0 || bus.hold !== 1'b0) begin
      fails++; $display("FAIL reset_cnt_hold: cnt %h hold %b want 0/0", bus.bubble_count, bus.hold);
    end
  endtask

  task automatic test_passthrough();
    ins_t i;
    i = rnd_ins(31);
    i.memread = 1'b0; i.aluop = 2'b10; i.regwrite = 1'b1; i.rd1 = 32'h00001234; i.rd = 5'd7;
    apply(i, 1'b0, 1'b0);
    tick();
    tests++;
    if (bus.ex_aluop !== 2'b10 || bus.ex_regwrite !== 1'b1 || bus.ex_rd1 !== 32'h00001234 ||
        bus.ex_rd !== 5'd7 || bus.ex_valid !== 1'b1) begin
      fails++; $display("FAIL passthrough_fields: aluop %b rw %b rd1 %h rd %0d v %b want 10/1/00001234/7/1",
                        bus.ex_aluop, bus.ex_regwrite, bus.ex_rd1, bus.ex_rd, bus.ex_valid);
    end
    tests++;
    if (dut_ex() !== m_ex) begin
      fails++; $display("FAIL passthrough_all: got %h want %h", dut_ex(), m_ex);
    end
  endtask

  task automatic test_load_use();
    ins_t lw, nx;
    int c0;
    lw = rnd_ins(31); lw.memread = 1'b1; lw.rt = 5'd5; lw.rs = 5'd1;
    nx = rnd_ins(31); nx.rs = 5'd5; nx.rt = 5'd3; nx.memread = 1'b0;
    c0 = int'(bus.bubble_count);
    apply(lw, 1'b0, 1'b0);
    tick();
    apply(nx, 1'b0, 1'b0);
    tests++;
    if (bus.hold !== 1'b1) begin
      fails++; $display("FAIL loaduse_hold1: got %b want 1", bus.hold);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_memread !== 1'b0 || bus.bubble_count !== 16'(c0 + 1)) begin
      fails++; $display("FAIL loaduse_bubble: v %b mr %b cnt %0d want 0/0/%0d",
                        bus.ex_valid, bus.ex_memread, bus.bubble_count, c0 + 1);
    end
    tests++;
    if (bus.hold !== 1'b0) begin
      fails++; $display("FAIL loaduse_hold2: got %b want 0", bus.hold);
    end
    tick();
    nx.valid = 1'b1;
    tests++;
    if (dut_ex() !== nx) begin
      fails++; $display("FAIL loaduse_load: got %h want %h", dut_ex(), nx);
    end
  endtask

  task automatic test_zero_reg();
    ins_t lw, nx;
    lw = rnd_ins(31); lw.memread = 1'b1; lw.rt = 5'd0;
    nx = rnd_ins(31); nx.rs = 5'd0; nx.rt = 5'd0;
    apply(lw, 1'b0, 1'b0);
    tick();
    apply(nx, 1'b0, 1'b0);
    tests++;
    if (bus.hold !== 1'b0) begin
      fails++; $display("FAIL zero_reg_hold: got %b want 0", bus.hold);
    end
    tick();
    nx.valid = 1'b1;
    tests++;
    if (dut_ex() !== nx) begin
      fails++; $display("FAIL zero_reg_load: got %h want %h", dut_ex(), nx);
    end
  endtask

  task automatic test_flush_hazard();
    ins_t lw, nx;
    int c0;
    lw = rnd_ins(31); lw.memread = 1'b1; lw.rt = 5'd9;
    nx = rnd_ins(31); nx.rs = 5'd9;
    apply(lw, 1'b0, 1'b0);
    tick();
    c0 = int'(bus.bubble_count);
    apply(nx, 1'b1, 1'b0);
    tests++;
    if (bus.hold !== 1'b0) begin
      fails++; $display("FAIL flush_hazard_hold: got %b want 0", bus.hold);
    end
    tick();
    tests++;
    if (dut_ex() !== ins_t'(0) || bus.bubble_count !== 16'(c0)) begin
      fails++; $display("FAIL flush_hazard_bubble: ex %h cnt %0d want 0/%0d",
                        dut_ex(), bus.bubble_count, c0);
    end
  endtask

  task automatic test_reset_mid_stall();
    ins_t lw, nx;
    lw = rnd_ins(31); lw.memread = 1'b1; lw.rt = 5'd12;
    nx = rnd_ins(31); nx.rt = 5'd12; nx.memread = 1'b0;
    apply(lw, 1'b0, 1'b0);
    tick();
    apply(nx, 1'b0, 1'b1);
    tick();
    tests++;
    if (dut_ex() !== ins_t'(0) || bus.bubble_count !== 16'd0 || bus.hold !== 1'b0) begin
      fails++; $display("FAIL reset_mid_stall: ex %h cnt %0d hold %b want 0/0/0",
                        dut_ex(), bus.bubble_count, bus.hold);
    end
    apply(nx, 1'b0, 1'b0);
    tick();
    nx.valid = 1'b1;
    tests++;
    if (dut_ex() !== nx) begin
      fails++; $display("FAIL reset_release_load: got %h want %h", dut_ex(), nx);
    end
  endtask

  task automatic test_random();
    ins_t i;
    logic fl, rs;
    for (int n = 0; n < 400; n++) begin
      i = rnd_ins(3);
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 49) == 0);
      apply(i, fl, rs);
      tests++;
      if (bus.hold !== m_hold()) begin
        fails++; $display("FAIL random_hold[%0d]: got %b want %b", n, bus.hold, m_hold());
      end
      tick();
      tests++;
      if (dut_ex() !== m_ex || bus.bubble_count !== 16'(m_cnt)) begin
        fails++; $display("FAIL random_state[%0d]: ex %h cnt %0d want %h/%0d",
                          n, dut_ex(), bus.bubble_count, m_ex, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    ins_t lw;
    lw = rnd_ins(31); lw.memread = 1'b1; lw.rt = 5'd5; lw.rs = 5'd5;
    apply(lw, 1'b0, 1'b1);
    tick();
    // Repeating a load that depends on itself alternates load / bubble
    for (int n = 0; n < 40; n++) begin
      apply(lw, 1'b0, 1'b0);
      tick();
    end
    tests++;
    if (bus.bubble_count !== 16'(m_cnt) || m_cnt != 20) begin
      fails++; $display("FAIL sat_ramp: got %0d want 20 (model %0d)", bus.bubble_count, m_cnt);
    end
    // Jump the counter close to its ceiling instead of spending 130k cycles
    force dut.bubble_count_q = 16'hFFFC;
    #1;
    release dut.bubble_count_q;
    m_cnt = 32'hFFFC;
    for (int n = 0; n < 16; n++) begin
      apply(lw, 1'b0, 1'b0);
      tick();
      tests++;
      if (bus.bubble_count !== 16'(m_cnt)) begin
        fails++; $display("FAIL sat_step[%0d]: got %h want %h", n, bus.bubble_count, 16'(m_cnt));
      end
    end
    tests++;
    if (bus.bubble_count !== 16'hFFFF) begin
      fails++; $display("FAIL sat_final: got %h want ffff", bus.bubble_count);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_zero_reg();
    test_flush_hazard();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter DW, default 32: datapath width of the PC, register-operand and immediate fields.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  branch taken downstream; squash the instruction currently in ID.
REQ-005 id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoded control from the main control decoder.
REQ-006 id_branch  in  2  bit0 = beq, bit1 = bne.
REQ-007 id_aluop  in  2  ALU operation class.
REQ-008 id_pc4, id_rd1, id_rd2, id_seimm  in  DW each  PC+4, register-file read data 1 and 2, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-010 ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_branch[1:0], ex_aluop[1:0], ex_pc4, ex_rd1, ex_rd2, ex_seimm, ex_rs, ex_rt, ex_rd  out  same widths  registered copies of the id_* inputs.
REQ-011 ex_valid  out  1  EX holds a real instruction, not a bubble.
REQ-012 hold  out  1  combinational; freezes the PC and the IF/ID register this cycle.
REQ-013 bubble_count  out  16  saturating count of load-use bubbles inserted.

Function
REQ-014 hazard = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)), evaluated combinationally from the current EX register and the current id_* inputs.
REQ-015 hold = hazard & ~flush; no other term drives hold.
REQ-016 Each edge without reset selects exactly one action, in priority order: flush, hazard, load.
REQ-017 Flush: write a bubble.
REQ-018 Hazard (no flush): write a bubble and increment bubble_count.
REQ-019 Load: capture every id_* field into the matching ex_* field and set ex_valid=1.
REQ-020 Bubble definition: every ex_* control, data and specifier field = 0 and ex_valid = 0.
REQ-021 Latency: an id_* value appears on ex_* exactly one edge after capture.
REQ-022 A load-use stall lasts exactly one cycle: the bubble clears ex_memread, so hazard deasserts on the next cycle and the held instruction loads on the following edge.
REQ-023 bubble_count increments by 1 per hazard-bubble edge and saturates at 16'hFFFF; it never wraps.
REQ-024 bubble_count does not change on flush edges, including edges where flush and hazard are both true.
REQ-025 A register specifier of 0 never causes a hazard.
REQ-026 Simultaneous flush and hazard: bubble written, hold=0, bubble_count unchanged.
REQ-027 id_branch and id_aluop pass through unmodified; the block performs no decoding.

Reset
REQ-028 While reset=1 at an edge, all ex_* outputs, ex_valid and bubble_count become 0, regardless of flush or hazard.
REQ-029 While reset=1, hold is still computed per REQ-015; because ex_memread is 0 after the first reset edge, hold=0 from then on.
REQ-030 Reset asserted mid-stall discards the pending bubble; the first edge after reset release performs a normal load.

Verification
REQ-031 Reset held for 2 cycles with all id_* nonzero and flush=1 -> all ex_* outputs = 0, ex_valid=0, hold=0, bubble_count=0.
REQ-032 Pass-through: id_aluop=2'b10, id_regwrite=1, id_rd1=32'h00001234, id_rd=5'd7 -> after one edge ex_aluop=2'b10, ex_regwrite=1, ex_rd1=32'h00001234, ex_rd=7, ex_valid=1.
REQ-033 Load-use: lw with id_memread=1, id_rt=5 loaded at edge N; next instruction has id_rs=5 -> hold=1 before edge N+1; after edge N+1 ex_valid=0 and bubble_count=1; hold=0 before edge N+2; the instruction loads at edge N+2.
REQ-034 Zero register: ex_memread=1, ex_rt=0, id_rs=0 -> hold=0 and the next edge performs a normal load.
REQ-035 Flush plus hazard in the same cycle -> hold=0, bubble written, bubble_count unchanged.
REQ-036 Saturation: 65 540 consecutive hazard bubbles -> bubble_count reads 16'hFFFF and remains there.
